// File: rtl/key_event.sv
// Key event generator: turns debounced key levels into press and auto-repeat
// events for a single locked key, lowest index winning on simultaneous presses.
module key_event #(
  parameter int N_KEYS        = 8,
  parameter int CODE_W        = 3,
  parameter int HOLD_DELAY    = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] btn,
  input  logic              repeat_en,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_repeat,
  output logic              key_held
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_DELAY - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_PERIOD - 1);

  state_e              state_q;
  logic [15:0]         cnt_q;
  logic [CODE_W-1:0]   lock_q;
  logic [N_KEYS-1:0]   btn_q;
  logic                key_valid_q;
  logic [CODE_W-1:0]   key_code_q;
  logic                key_repeat_q;

  logic [N_KEYS-1:0]   rise;
  logic [CODE_W-1:0]   first_idx;
  logic                lock_down;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rise      = btn & ~btn_q;
    first_idx = '0;
    lock_down = 1'b0;
    // Scan downward so the lowest rising index is the one left standing.
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) first_idx = CODE_W'(i);
    end
    for (int i = 0; i < N_KEYS; i++) begin
      if (lock_q == CODE_W'(i)) lock_down = btn[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lock_q       <= '0;
      // All ones: keys held through reset never look like a fresh press.
      btn_q        <= '1;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_repeat_q <= 1'b0;
    end else begin
      btn_q       <= btn;
      key_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|rise) begin
            state_q      <= ST_HELD;
            lock_q       <= first_idx;
            cnt_q        <= '0;
            key_valid_q  <= 1'b1;
            key_code_q   <= first_idx;
            key_repeat_q <= 1'b0;
          end
        end
        ST_HELD: begin
          if (!lock_down) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            // Saturated here until auto-repeat is allowed.
            if (repeat_en) begin
              state_q      <= ST_REPEAT;
              cnt_q        <= '0;
              key_valid_q  <= 1'b1;
              key_code_q   <= lock_q;
              key_repeat_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_REPEAT: begin
          if (!lock_down) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (repeat_en) begin
            if (cnt_q == REP_LAST) begin
              cnt_q        <= '0;
              key_valid_q  <= 1'b1;
              key_code_q   <= lock_q;
              key_repeat_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_repeat = key_repeat_q;
  assign key_held   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.
module tb_key_event;

  localparam int NK = 8;
  localparam int CW = 3;
  localparam int HD = 10;
  localparam int RP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] btn = '0;
  logic          repeat_en = 1'b0;
  logic          key_valid;
  logic [CW-1:0] key_code;
  logic          key_repeat;
  logic          key_held;

  int vectors = 0;
  int miscompares = 0;

  key_event #(
    .N_KEYS(NK),
    .CODE_W(CW),
    .HOLD_DELAY(HD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .repeat_en(repeat_en),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_repeat(key_repeat),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one locked key; "credit" is the number of counted held
  // cycles since the last event. Before the first repeat it counts every
  // cycle up to HD-1; afterwards it only counts cycles with repeat enabled.
  logic [NK-1:0] m_prev;
  bit            m_locked;
  int            m_key;
  bit            m_after_first;
  int            m_credit;
  bit            m_valid;
  int            m_code;
  bit            m_rep;

  task automatic model_reset();
    m_prev        = '1;
    m_locked      = 1'b0;
    m_key         = 0;
    m_after_first = 1'b0;
    m_credit      = 0;
    m_valid       = 1'b0;
    m_code        = 0;
    m_rep         = 1'b0;
  endtask

  task automatic model_step(input logic [NK-1:0] b, input logic en);
    logic [NK-1:0] r;
    int            need;
    r       = b & ~m_prev;
    m_valid = 1'b0;
    if (!m_locked) begin
      if (r != '0) begin
        m_key = -1;
        for (int i = 0; i < NK; i++)
          if (r[i] && m_key < 0) m_key = i;
        m_locked      = 1'b1;
        m_after_first = 1'b0;
        m_credit      = 0;
        m_valid       = 1'b1;
        m_code        = m_key;
        m_rep         = 1'b0;
      end
    end else if (!b[m_key]) begin
      m_locked = 1'b0;
    end else begin
      need = m_after_first ? RP - 1 : HD - 1;
      if (en && m_credit >= need) begin
        m_valid       = 1'b1;
        m_code        = m_key;
        m_rep         = 1'b1;
        m_credit      = 0;
        m_after_first = 1'b1;
      end else if (!m_after_first) begin
        if (m_credit < HD - 1) m_credit++;
      end else if (en) begin
        m_credit++;
      end
    end
    m_prev = b;
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    logic [CW-1:0] mc;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step(btn, repeat_en);
      else model_reset();
      @(negedge clk);
      if (!rst_n) model_reset();
      mc = m_code[CW-1:0];
      check("cycle {valid,code,repeat,held}",
            32'({key_valid, key_code, key_repeat, key_held}),
            32'({m_valid, mc, m_rep, m_locked}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_ev(input string name, input bit v, input int code, input bit rep,
                           input bit held);
    check({name, " valid"}, 32'(key_valid), 32'(v));
    check({name, " held"}, 32'(key_held), 32'(held));
    if (v) begin
      check({name, " code"}, 32'(key_code), 32'(code));
      check({name, " repeat"}, 32'(key_repeat), 32'(rep));
    end
  endtask

  initial begin
    int r;
    bit v;

    // Reset state
    repeat (3) tick();
    expect_ev("reset", 1'b0, 0, 1'b0, 1'b0);
    check("reset code", 32'(key_code), 32'd0);
    check("reset repeat", 32'(key_repeat), 32'd0);
    rst_n = 1'b1;
    tick();

    // Short press of key 2
    btn = 8'h04;
    tick(); expect_ev("short press", 1'b1, 2, 1'b0, 1'b1);
    tick(); expect_ev("short hold1", 1'b0, 0, 1'b0, 1'b1);
    tick(); expect_ev("short hold2", 1'b0, 0, 1'b0, 1'b1);
    btn = 8'h00;
    tick(); expect_ev("short release", 1'b0, 0, 1'b0, 1'b0);
    repeat (2) tick();

    // Long hold of key 0 with auto-repeat
    repeat_en = 1'b1;
    btn = 8'h01;
    for (int j = 1; j <= 30; j++) begin
      tick();
      v = (j == 1 || j == 11 || j == 15 || j == 19 || j == 23 || j == 27);
      expect_ev($sformatf("long hold j=%0d", j), v, 0, j != 1, 1'b1);
    end
    btn = 8'h00;
    repeat (2) tick();

    // Simultaneous rises: lowest wins, the other key is discarded
    repeat_en = 1'b0;
    btn = 8'h28;
    tick(); expect_ev("multi press", 1'b1, 3, 1'b0, 1'b1);
    btn = 8'h20;
    tick(); expect_ev("multi release3", 1'b0, 0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick(); expect_ev("multi key5 ignored", 1'b0, 0, 1'b0, 1'b0);
    end
    btn = 8'h00;
    tick();
    btn = 8'h20;
    tick(); expect_ev("multi repress5", 1'b1, 5, 1'b0, 1'b1);
    btn = 8'h00;
    repeat (2) tick();

    // Repeat disabled, then enabled after saturation
    repeat_en = 1'b0;
    btn = 8'h80;
    for (int j = 1; j <= 20; j++) begin
      tick();
      expect_ev($sformatf("gated hold j=%0d", j), (j == 1 || j == 16), 7, j == 16, 1'b1);
      if (j == 15) repeat_en = 1'b1;
      if (j == 16) repeat_en = 1'b0;
    end
    btn = 8'h00;
    repeat (2) tick();

    // Key held through a reset pulse
    btn = 8'h02;
    tick(); expect_ev("rst press", 1'b1, 1, 1'b0, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst async held", 32'(key_held), 32'd0);
    check("rst async valid", 32'(key_valid), 32'd0);
    check("rst async code", 32'(key_code), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(); expect_ev("rst held no event", 1'b0, 0, 1'b0, 1'b0);
    end
    btn = 8'h00;
    tick(); expect_ev("rst released", 1'b0, 0, 1'b0, 1'b0);
    btn = 8'h02;
    tick(); expect_ev("rst repress", 1'b1, 1, 1'b0, 1'b1);
    btn = 8'h00;
    repeat (2) tick();

    // Release on the very cycle the hold delay expires
    repeat_en = 1'b1;
    btn = 8'h01;
    for (int j = 1; j <= 10; j++) begin
      tick(); expect_ev("race hold", j == 1, 0, 1'b0, 1'b1);
    end
    btn = 8'h00;
    tick(); expect_ev("race release", 1'b0, 0, 1'b0, 1'b0);
    tick(); expect_ev("race idle", 1'b0, 0, 1'b0, 1'b0);

    // Randomized run, checked by the every-cycle compare process
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 499) != 0);
      r = $urandom_range(0, 39);
      case (r)
        0: btn = '0;
        1: btn = NK'(1) << $urandom_range(0, NK - 1);
        2: btn = NK'($urandom);
        3: btn = btn ^ (NK'(1) << $urandom_range(0, NK - 1));
        4: btn = btn | (NK'(1) << $urandom_range(0, NK - 1));
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
    end
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
